// File: rtl/periph_bus_if.sv
// periph_bus_if: bundles the core load/store port and the slave-side bus of
// the peripheral interconnect.
//   master modport : core view (drives requests, receives completion/error)
//   slave  modport : peripheral view (receives strobe/fields, returns data/ack)
//   fabric modport : interconnect view (the periph_bus module itself)
// Parameters N_SLV, XLEN and AW must match the periph_bus instance.
interface periph_bus_if #(
    parameter int N_SLV = 4,
    parameter int XLEN  = 32,
    parameter int AW    = 12
);
    // Master (core) side
    logic [AW-1:0]         m_addr;
    logic [XLEN-1:0]       m_wrData;
    logic                  m_wrEn;
    logic                  m_rdEn;
    logic [1:0]            m_size;
    logic                  m_busy;
    logic                  m_done;
    logic [XLEN-1:0]       m_rdData;
    logic                  m_err;
    logic [AW-1:0]         err_addr;

    // Slave (peripheral) side
    logic [N_SLV-1:0]      s_sel;
    logic [AW-1:0]         s_addr;
    logic [XLEN-1:0]       s_wrData;
    logic [1:0]            s_size;
    logic                  s_wrEn;
    logic                  s_rdEn;
    logic [N_SLV*XLEN-1:0] s_rdData;
    logic [N_SLV-1:0]      s_ack;

    modport master (
        output m_addr, m_wrData, m_wrEn, m_rdEn, m_size,
        input  m_busy, m_done, m_rdData, m_err, err_addr
    );

    modport slave (
        input  s_sel, s_addr, s_wrData, s_size, s_wrEn, s_rdEn,
        output s_rdData, s_ack
    );

    modport fabric (
        input  m_addr, m_wrData, m_wrEn, m_rdEn, m_size,
        output m_busy, m_done, m_rdData, m_err, err_addr,
        output s_sel, s_addr, s_wrData, s_size, s_wrEn, s_rdEn,
        input  s_rdData, s_ack
    );
endinterface

// File: rtl/periph_bus.sv
// periph_bus: memory-mapped peripheral interconnect.
// Decodes a core request against N_SLV base/mask windows (lowest index wins),
// issues a one-cycle strobe to the selected slave, waits for its ack with a
// timeout, and reports either a one-cycle m_done or a one-cycle m_err.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - synchronous active-high reset
//   bus  - periph_bus_if.fabric: m_* core port and s_* slave bus
// All outputs are registered.
module periph_bus #(
    parameter int                  N_SLV    = 4,
    parameter int                  XLEN     = 32,
    parameter int                  AW       = 12,
    parameter logic [N_SLV*AW-1:0] SLV_BASE = {12'h700, 12'h600, 12'h500, 12'h000},
    parameter logic [N_SLV*AW-1:0] SLV_MASK = {12'hFF0, 12'hFF0, 12'hFF0, 12'hC00},
    parameter int                  TIMEOUT  = 15
) (
    input  logic           clk,
    input  logic           rst,
    periph_bus_if.fabric   bus
);

    localparam int SW = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_STRB = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [SW-1:0]    slot_q,   slot_d;
    logic             wr_q,     wr_d;
    logic [AW-1:0]    addr_q,   addr_d;
    logic [XLEN-1:0]  wdata_q,  wdata_d;
    logic [1:0]       size_q,   size_d;
    logic [N_SLV-1:0] sel_q,    sel_d;
    logic             swr_q,    swr_d;
    logic             srd_q,    srd_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             err_q,    err_d;
    logic [XLEN-1:0]  rdata_q,  rdata_d;
    logic [AW-1:0]    eaddr_q,  eaddr_d;

    logic             hit_s;
    logic [SW-1:0]    hit_idx_s;
    logic             req_s;
    logic             illegal_s;
    logic             ack_s;

    // Address decode: scanning from the top index down lets the lowest match win.
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if ((bus.m_addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
                hit_s     = 1'b1;
                hit_idx_s = SW'(i);
            end else begin
                hit_s     = hit_s;
            end
        end
    end

    assign req_s     = bus.m_wrEn | bus.m_rdEn;
    assign illegal_s = bus.m_wrEn & bus.m_rdEn;
    // Only the latched slot's ack matters; acks from other slots are ignored.
    assign ack_s     = bus.s_ack[slot_q];

    // Next-state logic for the transaction FSM and all registered outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        rdata_d = rdata_q;
        eaddr_d = eaddr_q;
        sel_d   = '0;
        swr_d   = 1'b0;
        srd_d   = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_s) begin
                    addr_d  = bus.m_addr;
                    wdata_d = bus.m_wrData;
                    size_d  = bus.m_size;
                    wr_d    = bus.m_wrEn;
                    if (hit_s && !illegal_s) begin
                        state_d          = S_STRB;
                        slot_d           = hit_idx_s;
                        sel_d[hit_idx_s] = 1'b1;
                        swr_d            = bus.m_wrEn;
                        srd_d            = bus.m_rdEn;
                        cnt_d            = CW'(1);
                    end else begin
                        // Unmapped or both directions requested: error, no strobe.
                        err_d   = 1'b1;
                        eaddr_d = bus.m_addr;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_STRB, S_WAIT: begin
                if (ack_s) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    if (!wr_q) begin
                        rdata_d = bus.s_rdData[int'(slot_q)*XLEN +: XLEN];
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if (cnt_q >= TO_CNT) begin
                    // cnt_q equals the cycles spent since the strobe, so an ack on
                    // the TIMEOUT-th cycle still wins over the timeout.
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    eaddr_d = addr_q;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            slot_q  <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= 2'b00;
            sel_q   <= '0;
            swr_q   <= 1'b0;
            srd_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            eaddr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            sel_q   <= sel_d;
            swr_q   <= swr_d;
            srd_q   <= srd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            eaddr_q <= eaddr_d;
        end
    end

    assign bus.m_busy   = busy_q;
    assign bus.m_done   = done_q;
    assign bus.m_err    = err_q;
    assign bus.m_rdData = rdata_q;
    assign bus.err_addr = eaddr_q;
    assign bus.s_sel    = sel_q;
    assign bus.s_addr   = addr_q;
    assign bus.s_wrData = wdata_q;
    assign bus.s_size   = size_q;
    assign bus.s_wrEn   = swr_q;
    assign bus.s_rdEn   = srd_q;

endmodule

// File: tb/tb_periph_bus.sv
// tb_periph_bus: randomized + directed bench for periph_bus.
// Stimulus pushes the expected completion (kind, cycle, read data, err_addr)
// into a queue; a negedge monitor pops and compares whenever m_done/m_err fires.
// Cycle numbering: the request is driven in cycle T (cyc==T), registered
// outputs for T+1 are sampled at the negedge where cyc==T+1.
module tb_periph_bus;
    localparam int N_SLV   = 4;
    localparam int XLEN    = 32;
    localparam int AW      = 12;
    localparam int TIMEOUT = 15;

    localparam logic [11:0] REF_BASE [4] = '{12'h000, 12'h500, 12'h600, 12'h700};
    localparam logic [11:0] REF_MASK [4] = '{12'hC00, 12'hFF0, 12'hFF0, 12'hFF0};

    typedef struct {
        bit          is_err;
        int          cyc;
        logic [31:0] rdata;
        logic [11:0] eaddr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    logic [31:0] last_rd;
    logic [11:0] last_err;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    periph_bus_if #(.N_SLV(N_SLV), .XLEN(XLEN), .AW(AW)) bif ();

    periph_bus #(.N_SLV(N_SLV), .XLEN(XLEN), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference decode straight from the address map: first matching window.
    function automatic int ref_decode(input logic [11:0] a);
        for (int i = 0; i < 4; i++) begin
            if ((a & REF_MASK[i]) == REF_BASE[i]) return i;
        end
        return -1;
    endfunction

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0 && q[0].cyc < cyc) begin
            chk("resp_missing", 32'd0, 32'd1);
            void'(q.pop_front());
        end
        if (bif.m_done || bif.m_err) begin
            chk("pulse_exclusive", {31'd0, bif.m_done & bif.m_err}, 32'd0);
            if (q.size() == 0) begin
                chk("resp_unexpected", {31'd0, bif.m_err}, {31'd0, bif.m_done});
                chk("resp_unexpected", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("resp_kind_err", {31'd0, bif.m_err}, {31'd0, e.is_err});
                chk("resp_cycle", cyc, e.cyc);
                chk("resp_rdData", bif.m_rdData, e.rdata);
                chk("resp_err_addr", {20'd0, bif.err_addr}, {20'd0, e.eaddr});
            end
        end
    end

    // One transaction, acting also as the slave: w = ack delay after strobe
    // (w >= TIMEOUT means never). rd0 != 0 forces the selected slot's data.
    task automatic txn(input logic [11:0] addr, input bit wr, input bit rd,
                       input logic [31:0] wd, input int w, input bit stray_req,
                       input bit stray_ack, input logic [31:0] rd0);
        int t, k, last, other;
        bit hit;
        logic [1:0] sz;
        logic [127:0] rdv;
        exp_t e;
        t     = cyc;
        k     = ref_decode(addr);
        hit   = (k >= 0) && !(wr && rd);
        sz    = 2'($urandom_range(0, 2));
        rdv   = {$urandom, $urandom, $urandom, $urandom};
        if (k >= 0 && rd0 != 32'd0) rdv[k*32 +: 32] = rd0;
        other = (k == 3) ? 0 : 3;

        if (!hit) begin
            e.is_err = 1'b1; e.cyc = t + 1; last_err = addr;
        end else if (w < TIMEOUT) begin
            e.is_err = 1'b0; e.cyc = t + 2 + w;
            if (rd) last_rd = rdv[k*32 +: 32];
        end else begin
            e.is_err = 1'b1; e.cyc = t + TIMEOUT + 1; last_err = addr;
        end
        e.rdata = last_rd;
        e.eaddr = last_err;
        q.push_back(e);

        bif.s_rdData = rdv;
        bif.s_ack    = 4'b0000;
        bif.m_addr   = addr;
        bif.m_wrData = wd;
        bif.m_size   = sz;
        bif.m_wrEn   = wr;
        bif.m_rdEn   = rd;

        @(negedge clk);
        bif.m_wrEn = 1'b0;
        bif.m_rdEn = 1'b0;
        if (!hit) begin
            chk("err_no_sel", {28'd0, bif.s_sel}, 32'd0);
            chk("err_no_busy", {31'd0, bif.m_busy}, 32'd0);
            return;
        end
        chk("strb_sel", {28'd0, bif.s_sel}, 32'd1 << k);
        chk("strb_wrEn", {31'd0, bif.s_wrEn}, {31'd0, wr});
        chk("strb_rdEn", {31'd0, bif.s_rdEn}, {31'd0, rd});
        chk("strb_addr", {20'd0, bif.s_addr}, {20'd0, addr});
        chk("strb_size", {30'd0, bif.s_size}, {30'd0, sz});
        chk("strb_wrData", bif.s_wrData, wd);
        chk("strb_busy", {31'd0, bif.m_busy}, 32'd1);
        if (w == 0) bif.s_ack[k] = 1'b1;
        if (stray_req) begin
            bif.m_addr = 12'h700;
            bif.m_rdEn = 1'b1;
        end

        last = (w < TIMEOUT) ? w + 1 : TIMEOUT;
        for (int j = 1; j <= last; j++) begin
            @(negedge clk);
            bif.s_ack  = 4'b0000;
            bif.m_rdEn = 1'b0;
            bif.m_wrEn = 1'b0;
            chk("post_sel_low", {28'd0, bif.s_sel}, 32'd0);
            chk("post_strobe_low", {30'd0, bif.s_wrEn, bif.s_rdEn}, 32'd0);
            if (j < last) begin
                chk("wait_busy", {31'd0, bif.m_busy}, 32'd1);
                chk("wait_wrData_held", bif.s_wrData, wd);
                chk("wait_addr_held", {20'd0, bif.s_addr}, {20'd0, addr});
            end else begin
                chk("end_busy_low", {31'd0, bif.m_busy}, 32'd0);
            end
            if (j == w) bif.s_ack[k] = 1'b1;
            else if (stray_ack && j == 1) bif.s_ack[other] = 1'b1;
        end
    endtask

    initial begin
        int t;
        logic [11:0] a;
        int sel, w;
        bit both, wr;
        rst = 1'b1;
        bif.m_addr = 12'h000; bif.m_wrData = 32'd0; bif.m_wrEn = 1'b0;
        bif.m_rdEn = 1'b0; bif.m_size = 2'b00; bif.s_rdData = '0; bif.s_ack = 4'b0000;
        last_rd = 32'd0; last_err = 12'h000;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, bif.m_busy}, 32'd0);
        chk("rst_done_err", {30'd0, bif.m_done, bif.m_err}, 32'd0);
        chk("rst_rdData", bif.m_rdData, 32'd0);
        chk("rst_err_addr", {20'd0, bif.err_addr}, 32'd0);
        chk("rst_sel_strobes", {26'd0, bif.s_sel, bif.s_wrEn, bif.s_rdEn}, 32'd0);
        chk("rst_fields", {bif.s_addr, 2'b00, bif.s_size} | bif.s_wrData, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed scenarios
        txn(12'h010, 1'b0, 1'b1, 32'd0, 0, 1'b0, 1'b0, 32'hDEADBEEF);
        txn(12'h502, 1'b1, 1'b0, 32'h41, 3, 1'b0, 1'b0, 32'd0);
        txn(12'h600, 1'b0, 1'b1, 32'd0, 99, 1'b0, 1'b0, 32'd0);
        txn(12'h000, 1'b0, 1'b1, 32'd0, 0, 1'b0, 1'b0, 32'h12345678);
        txn(12'h800, 1'b0, 1'b1, 32'd0, 0, 1'b0, 1'b0, 32'd0);
        txn(12'h004, 1'b1, 1'b1, 32'd7, 0, 1'b0, 1'b0, 32'd0);
        txn(12'h020, 1'b0, 1'b1, 32'd0, 0, 1'b1, 1'b0, 32'hA5A5A5A5);
        txn(12'h030, 1'b0, 1'b1, 32'd0, 0, 1'b0, 1'b0, 32'h5A5A5A5A);
        txn(12'h040, 1'b0, 1'b1, 32'd0, 4, 1'b0, 1'b1, 32'hCAFEF00D);
        txn(12'h704, 1'b0, 1'b1, 32'd0, TIMEOUT - 1, 1'b0, 1'b0, 32'h0BADCAFE);
        txn(12'h510, 1'b1, 1'b0, 32'd9, 0, 1'b0, 1'b0, 32'd0);

        // Reset in the middle of a stalled slot-1 read; the late ack is ignored.
        t = cyc;
        bif.m_addr = 12'h508; bif.m_rdEn = 1'b1;
        @(negedge clk);
        bif.m_rdEn = 1'b0;
        chk("rstw_sel", {28'd0, bif.s_sel}, 32'd2);
        repeat (2) @(negedge clk);
        chk("rstw_cycle", cyc, t + 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bif.s_ack = 4'b0010;
        last_rd = 32'd0; last_err = 12'h000;
        chk("rstw_busy", {31'd0, bif.m_busy}, 32'd0);
        chk("rstw_rdData", bif.m_rdData, 32'd0);
        chk("rstw_err_addr", {20'd0, bif.err_addr}, 32'd0);
        chk("rstw_sel", {28'd0, bif.s_sel}, 32'd0);
        chk("rstw_addr", {20'd0, bif.s_addr}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            bif.s_ack = 4'b0000;
            chk("rstw_no_pulse", {30'd0, bif.m_done, bif.m_err}, 32'd0);
            chk("rstw_idle", {31'd0, bif.m_busy}, 32'd0);
        end

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 3);
            a = 12'($urandom_range(0, 4095));
            if (sel == 1) a = {8'h50, a[3:0]};
            else if (sel == 2) a = {8'h60, a[3:0]};
            else if (sel == 3) a = {8'h70, a[3:0]};
            both = ($urandom_range(0, 9) == 0);
            wr = $urandom_range(0, 1) == 1;
            w = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 1)
                                             : $urandom_range(0, 5);
            txn(a, both | wr, both | !wr, $urandom, w, $urandom_range(0, 3) == 0,
                $urandom_range(0, 1) == 1, 32'd0);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/periph_bus.md
# periph_bus

Parametrised memory-mapped peripheral interconnect between the core load/store port and N slave peripherals (RAM controller, UART, timers, GPIO). It replaces the fixed two-slot read-data mux with:
- base/mask address decode;
- a one-cycle slave strobe;
- an ack handshake that supports wait-stated slaves;
- a bus-error path for unmapped addresses, illegal requests and slave timeouts.

## Interface
Parameters:
- N_SLV, 4, number of slave slots (1..8)
- XLEN, 32, data width
- AW, 12, decoded address width
- SLV_BASE, {12'h700,12'h600,12'h500,12'h000}, packed N_SLV*AW; slot i base at [i*AW +: AW]
- SLV_MASK, {12'hFF0,12'hFF0,12'hFF0,12'hC00}, packed N_SLV*AW; slot i hits when (m_addr & mask_i) == base_i
- TIMEOUT, 15, max cycles to wait for ack (>=1)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- m_addr  in  AW  master byte address
- m_wrData  in  XLEN  master write data
- m_wrEn  in  1  master write request
- m_rdEn  in  1  master read request
- m_size  in  2  00 byte, 01 half, 10 word; forwarded unchanged
- m_busy  out  1  transaction outstanding; master must not request while high
- m_done  out  1  one-cycle pulse, successful completion (read or write)
- m_rdData  out  XLEN  read data; valid with m_done of a read, held until next read completion
- m_err  out  1  one-cycle pulse, bus error
- err_addr  out  AW  address of most recent error (sticky)
- s_sel  out  N_SLV  one-hot slave select, high only during strobe cycle
- s_addr, s_wrData, s_size  out  AW, XLEN, 2  latched request fields, stable from strobe through completion
- s_wrEn, s_rdEn  out  1 each  strobe, high exactly one cycle
- s_rdData  in  N_SLV*XLEN  slave i read data at [i*XLEN +: XLEN]
- s_ack  in  N_SLV  slave completion, level sampled

## Operation
FSM states: IDLE, STRB, WAIT.
- **IDLE.** On a request (m_wrEn|m_rdEn):
  - Latch addr/data/size/direction.
  - Decode by priority: lowest matching index wins on overlap.
  - Hit: go to STRB.
  - Miss, or m_wrEn&m_rdEn both high: no strobe, stay IDLE, pulse m_err next cycle, load err_addr.
- **STRB.** Drive s_sel[k] and the s_wrEn or s_rdEn strobe for one cycle. Timeout counter = 1.
  - s_ack[k] high: complete.
  - Otherwise: go to WAIT.
- **WAIT.** Strobes low; s_sel low; latched fields held. Counter increments each cycle.
  - s_ack[k] high: complete.
  - Counter reaches TIMEOUT without ack: error.
- **Complete.** State returns to IDLE. Registered m_done pulse next cycle; for a read, m_rdData <= s_rdData[k] in the same edge.
- **Error (timeout).** State returns to IDLE. m_err pulse, err_addr <= latched addr, m_rdData unchanged.
- Acks from non-selected slots, and any ack while IDLE, are ignored.
- Requests while m_busy is high are ignored (not queued).
- m_busy = (state != IDLE), registered.
- Reset values:
  - state IDLE, counter 0, all strobes/s_sel 0;
  - m_busy, m_done, m_err 0;
  - m_rdData 0, err_addr 0, latched fields 0.
- Reset mid-transaction aborts it: no m_done/m_err is produced, and a later ack is ignored.

## Timing
All timings are relative to request sampled in IDLE at cycle T.
- **Strobe:** s_sel/strobe at T+1; m_busy high from T+1.
- **Zero-wait ack:** ack at T+1 gives m_done at T+2 and m_busy low at T+2; a new request is accepted at T+2, for 2-cycle throughput.
- **Wait-stated ack:** ack at T+1+w (w < TIMEOUT) gives m_done at T+2+w.
- **Timeout:** no ack through T+TIMEOUT gives m_err at T+TIMEOUT+1. An ack arriving at T+TIMEOUT still completes normally.
- **Unmapped/illegal:** m_err at T+1; m_busy never rises; next request accepted at T+1.
- **Pulse exclusivity:** m_done and m_err are never high together; each lasts exactly one cycle.

## Test plan
- **Zero-wait read:** defaults; read addr 0x010 at T, slot 0 acks in strobe cycle with 0xDEADBEEF -> s_sel=0001 at T+1, m_done and m_rdData=0xDEADBEEF at T+2, m_busy high only at T+1.
- **Wait-stated write:** write 0x502 data 0x41, slot 1 acks 3 cycles after strobe -> s_wrEn one cycle at T+1, s_wrData held 0x41 through T+4, m_done at T+5, m_rdData unchanged.
- **Timeout:** read 0x600, slot 2 never acks, TIMEOUT=15 -> m_err at T+16, err_addr=0x600, no m_done. Then a read of 0x000 completes normally.
- **Unmapped and illegal:** read 0x800 -> m_err at T+1, s_sel stays 0, err_addr=0x800. Simultaneous wrEn&rdEn at 0x004 -> m_err, err_addr=0x004.
- **Back-to-back and stray ack:** two zero-wait reads at T and T+2 -> m_done at T+2 and T+4. s_ack[3] pulsed during slot-0 WAIT is ignored. A request at T+1 while m_busy is high is dropped.
- **Reset mid-WAIT:** assert rst at T+3 of a stalled slot-1 read, then ack at T+4 -> no m_done/m_err; all outputs at reset values from T+4.
